// File: rtl/branch_predictor.sv
// Fetch-side predictor for conditional jumps, built on a table of 2-bit saturating counters.
// It also recovers from mispredicts with a one-cycle redirect and a flush that lasts FLUSH_CYCLES cycles.
module branch_predictor #(
  parameter int         INDEX_BITS   = 4,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] CNT_INIT     = 2'b01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        q_valid,
  input  logic [3:0]  q_ifun,
  input  logic [31:0] q_valC,
  input  logic [31:0] q_valP,
  output logic        p_valid,
  output logic        p_taken,
  output logic [31:0] p_pc,
  input  logic        r_valid,
  input  logic        r_taken,
  input  logic        r_pred,
  input  logic [31:0] r_valC,
  input  logic [31:0] r_valP,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t                  state;
  logic [2:0]              flush_cnt;
  logic [1:0]              counters [ENTRIES];

  logic [INDEX_BITS-1:0]   q_idx;
  logic [INDEX_BITS-1:0]   r_idx;
  logic                    q_pred_taken;
  logic                    accept;
  logic                    mispredict;
  logic [1:0]              ctr_cur;
  logic [1:0]              ctr_next;

  assign q_idx = q_valP[INDEX_BITS-1:0];
  assign r_idx = r_valP[INDEX_BITS-1:0];

  // The counter is read before this cycle's training write. A query and a
  // resolve that hit the same index therefore see the old value.
  assign q_pred_taken = (q_ifun == 4'd0) | counters[q_idx][1];

  // Resolutions that arrive while the flush is active belong to squashed
  // instructions, so they must never train the table or raise a redirect.
  assign accept     = r_valid && (state == IDLE);
  assign mispredict = accept && (r_taken != r_pred);
  assign ctr_cur    = counters[r_idx];

  // NOTE: always_comb gets a default for every output on entry, so no path can infer a latch.
  always_comb begin
    ctr_next = ctr_cur;
    if (r_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  // NOTE: the counter table is reset explicitly. It is small enough to be
  // flops, and a reset in the middle of a flush must return every entry to CNT_INIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= CNT_INIT;
    end else if (accept) begin
      counters[r_idx] <= ctr_next;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments. Then every read in this
  // block sees the value from before the edge, whatever order the statements are in.
  always_ff @(posedge clock) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_taken <= 1'b0;
      p_pc    <= 32'd0;
    end else if (q_valid && (state == IDLE)) begin
      p_valid <= 1'b1;
      p_taken <= q_pred_taken;
      p_pc    <= q_pred_taken ? q_valC : q_valP;
    end else begin
      p_valid <= 1'b0;
    end
  end

  // Recovery FSM. The state is FLUSH for exactly FLUSH_CYCLES cycles, and the
  // flush output is registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      flush_cnt   <= 3'd0;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      flush       <= 1'b0;
      mispredicts <= 16'd0;
    end else begin
      redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (mispredict) begin
            redirect    <= 1'b1;
            redirect_pc <= r_taken ? r_valC : r_valP;
            flush       <= 1'b1;
            flush_cnt   <= 3'(FLUSH_CYCLES - 1);
            state       <= FLUSH;
            if (mispredicts != 16'hFFFF) mispredicts <= mispredicts + 16'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor. It also runs hand sequences that cover
// the flush window, the accept-again timing and a reset in the middle of a flush.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic        q_valid;
  logic [3:0]  q_ifun;
  logic [31:0] q_valC, q_valP;
  logic        p_valid, p_taken;
  logic [31:0] p_pc;
  logic        r_valid, r_taken, r_pred;
  logic [31:0] r_valC, r_valP;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] mispredicts;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  branch_predictor #(.INDEX_BITS(4), .FLUSH_CYCLES(2), .CNT_INIT(2'b01)) dut (
    .clock(clock), .reset(reset),
    .q_valid(q_valid), .q_ifun(q_ifun), .q_valC(q_valC), .q_valP(q_valP),
    .p_valid(p_valid), .p_taken(p_taken), .p_pc(p_pc),
    .r_valid(r_valid), .r_taken(r_taken), .r_pred(r_pred),
    .r_valC(r_valC), .r_valP(r_valP),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .mispredicts(mispredicts)
  );

  typedef struct {
    logic        qv;
    logic [3:0]  qf;
    logic [31:0] qc;
    logic [31:0] qp;
    logic        rv;
    logic        rt;
    logic        rp;
    logic [31:0] rc;
    logic [31:0] rvp;
    logic        e_pv;
    logic        e_pt;
    logic [31:0] e_pc;
    logic        e_rd;
    logic [31:0] e_rpc;
    logic        e_fl;
    logic [15:0] e_mp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    q_valid = 1'b0; q_ifun = 4'd0; q_valC = 32'd0; q_valP = 32'd0;
    r_valid = 1'b0; r_taken = 1'b0; r_pred = 1'b0; r_valC = 32'd0; r_valP = 32'd0;
  endtask

  task automatic drive_query(input logic [3:0] f, input logic [31:0] c, input logic [31:0] p);
    q_valid = 1'b1; q_ifun = f; q_valC = c; q_valP = p;
  endtask

  task automatic drive_resolve(input logic t, input logic pr, input logic [31:0] c, input logic [31:0] p);
    r_valid = 1'b1; r_taken = t; r_pred = pr; r_valC = c; r_valP = p;
  endtask

  initial begin
    // Each vector holds: query inputs, resolve inputs, then the outputs expected after the edge.
    vecs[0]  = '{1, 3, 'h80, 'h13, 0, 0, 0, 0, 0,         1, 0, 'h13, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0,       1, 1, 0, 'h40, 'h13,   0, 0, 'h13, 1, 'h40, 1, 1};
    vecs[2]  = '{0, 0, 0, 0,       0, 0, 0, 0, 0,         0, 0, 'h13, 0, 'h40, 1, 1};
    vecs[3]  = '{0, 0, 0, 0,       0, 0, 0, 0, 0,         0, 0, 'h13, 0, 'h40, 0, 1};
    vecs[4]  = '{1, 3, 'h90, 'h23, 0, 0, 0, 0, 0,         1, 1, 'h90, 0, 'h40, 0, 1};
    vecs[5]  = '{0, 0, 0, 0,       1, 1, 1, 'h50, 'h05,   0, 1, 'h90, 0, 'h40, 0, 1};
    vecs[6]  = '{0, 0, 0, 0,       1, 1, 1, 'h50, 'h05,   0, 1, 'h90, 0, 'h40, 0, 1};
    vecs[7]  = '{0, 0, 0, 0,       1, 1, 1, 'h50, 'h05,   0, 1, 'h90, 0, 'h40, 0, 1};
    vecs[8]  = '{0, 0, 0, 0,       1, 1, 1, 'h50, 'h05,   0, 1, 'h90, 0, 'h40, 0, 1};
    vecs[9]  = '{0, 0, 0, 0,       1, 0, 0, 'h50, 'h05,   0, 1, 'h90, 0, 'h40, 0, 1};
    vecs[10] = '{1, 2, 'hA0, 'h15, 0, 0, 0, 0, 0,         1, 1, 'hA0, 0, 'h40, 0, 1};
    vecs[11] = '{1, 0, 'hB0, 'h06, 0, 0, 0, 0, 0,         1, 1, 'hB0, 0, 'h40, 0, 1};
    vecs[12] = '{1, 1, 'hB0, 'h06, 0, 0, 0, 0, 0,         1, 0, 'h06, 0, 'h40, 0, 1};
    vecs[13] = '{1, 3, 'hC0, 'h17, 1, 1, 1, 'hC0, 'h07,   1, 0, 'h17, 0, 'h40, 0, 1};
    vecs[14] = '{1, 3, 'hC0, 'h17, 0, 0, 0, 0, 0,         1, 1, 'hC0, 0, 'h40, 0, 1};
    vecs[15] = '{0, 0, 0, 0,       1, 0, 0, 'hD0, 'h08,   0, 1, 'hC0, 0, 'h40, 0, 1};
    vecs[16] = '{0, 0, 0, 0,       1, 0, 0, 'hD0, 'h08,   0, 1, 'hC0, 0, 'h40, 0, 1};
    vecs[17] = '{1, 4, 'hD0, 'h08, 0, 0, 0, 0, 0,         1, 0, 'h08, 0, 'h40, 0, 1};

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check("rst_p_valid", 32'(p_valid), 32'd0);
    check("rst_p_taken", 32'(p_taken), 32'd0);
    check("rst_p_pc", p_pc, 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_mispredicts", 32'(mispredicts), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      q_valid = vecs[i].qv; q_ifun = vecs[i].qf; q_valC = vecs[i].qc; q_valP = vecs[i].qp;
      r_valid = vecs[i].rv; r_taken = vecs[i].rt; r_pred = vecs[i].rp;
      r_valC = vecs[i].rc; r_valP = vecs[i].rvp;
      step();
      check($sformatf("v%0d_p_valid", i), 32'(p_valid), 32'(vecs[i].e_pv));
      check($sformatf("v%0d_p_taken", i), 32'(p_taken), 32'(vecs[i].e_pt));
      check($sformatf("v%0d_p_pc", i), p_pc, vecs[i].e_pc);
      check($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vecs[i].e_rd));
      check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      check($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_fl));
      check($sformatf("v%0d_mispredicts", i), 32'(mispredicts), 32'(vecs[i].e_mp));
    end

    // A not-taken mispredict on idx 9 redirects to the fall-through address.
    idle_inputs();
    drive_resolve(1'b0, 1'b1, 32'h99, 32'h29);
    step();
    check("nt_redirect", 32'(redirect), 32'd1);
    check("nt_redirect_pc", redirect_pc, 32'h29);
    check("nt_mispredicts", 32'(mispredicts), 32'd2);

    // Both flush cycles ignore queries and resolutions.
    idle_inputs();
    drive_resolve(1'b1, 1'b0, 32'h77, 32'h2A);
    drive_query(4'd3, 32'h55, 32'h2A);
    step();
    check("fl1_redirect", 32'(redirect), 32'd0);
    check("fl1_flush", 32'(flush), 32'd1);
    check("fl1_p_valid", 32'(p_valid), 32'd0);
    check("fl1_mispredicts", 32'(mispredicts), 32'd2);
    step();
    check("fl2_redirect", 32'(redirect), 32'd0);
    check("fl2_flush", 32'(flush), 32'd0);
    check("fl2_p_valid", 32'(p_valid), 32'd0);
    check("fl2_mispredicts", 32'(mispredicts), 32'd2);

    // The first edge after the flush accepts again. Idx 10 was never trained, so it stays not-taken.
    idle_inputs();
    drive_query(4'd3, 32'h55, 32'h2A);
    drive_resolve(1'b1, 1'b0, 32'h60, 32'h2B);
    step();
    check("acc_p_valid", 32'(p_valid), 32'd1);
    check("acc_p_taken", 32'(p_taken), 32'd0);
    check("acc_p_pc", p_pc, 32'h2A);
    check("acc_redirect", 32'(redirect), 32'd1);
    check("acc_redirect_pc", redirect_pc, 32'h60);
    check("acc_flush", 32'(flush), 32'd1);
    check("acc_mispredicts", 32'(mispredicts), 32'd3);

    // Reset lands on the second flush cycle.
    idle_inputs();
    step();
    check("pre_rst_flush", 32'(flush), 32'd1);
    check("pre_rst_redirect", 32'(redirect), 32'd0);
    reset = 1'b1;
    step();
    check("mid_rst_flush", 32'(flush), 32'd0);
    check("mid_rst_mispredicts", 32'(mispredicts), 32'd0);
    check("mid_rst_redirect_pc", redirect_pc, 32'd0);
    reset = 1'b0;
    drive_query(4'd3, 32'h80, 32'h13);
    step();
    check("post_rst_p_valid", 32'(p_valid), 32'd1);
    check("post_rst_p_taken", 32'(p_taken), 32'd0);
    check("post_rst_p_pc", p_pc, 32'h13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
